id_ex_pipe_stage: RTL and testbench

//  Parametrised ID->EX pipeline stage register for the 5-stage RISC-V core; successor to the

---
 rtl/pipe_pkg.sv | 55 +++++
 rtl/load_use_detect.sv | 29 ++
 rtl/id_ex_pipe_stage.sv | 189 ++++++++++++++++++
 tb/tb_id_ex_pipe_stage.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared defaults, stage-update select encoding and channel pack/unpack helpers
// for the ID->EX pipeline stage and its load-use comparator.
package pipe_pkg;

    localparam int DATA_W_DEF     = 32;
    localparam int RADDR_W_DEF    = 5;
    localparam int NUM_SRC_DEF    = 2;
    localparam int WB_W_DEF       = 2;
    localparam int M_W_DEF        = 2;
    localparam int EX_W_DEF       = 4;
    localparam int MEM_RD_BIT_DEF = 0;
    localparam int CNT_W_DEF      = 16;
    localparam int SRC_MAX        = 3;

    // Control value loaded into every ctrl bundle bit when a bubble is inserted
    localparam logic BUBBLE_CTRL = 1'b0;

    typedef enum logic [1:0] {
        SEL_LOAD   = 2'd0,
        SEL_STALL  = 2'd1,
        SEL_FLUSH  = 2'd2,
        SEL_BUBBLE = 2'd3
    } stage_sel_e;

    function automatic logic [SRC_MAX*DATA_W_DEF-1:0] data_pack(
        input logic [DATA_W_DEF-1:0] d0,
        input logic [DATA_W_DEF-1:0] d1,
        input logic [DATA_W_DEF-1:0] d2
    );
        return {d2, d1, d0};
    endfunction

    function automatic logic [DATA_W_DEF-1:0] data_chan(
        input logic [SRC_MAX*DATA_W_DEF-1:0] bus,
        input int unsigned                   k
    );
        return bus[k*DATA_W_DEF +: DATA_W_DEF];
    endfunction

    function automatic logic [SRC_MAX*RADDR_W_DEF-1:0] addr_pack(
        input logic [RADDR_W_DEF-1:0] a0,
        input logic [RADDR_W_DEF-1:0] a1,
        input logic [RADDR_W_DEF-1:0] a2
    );
        return {a2, a1, a0};
    endfunction

    function automatic logic [RADDR_W_DEF-1:0] addr_chan(
        input logic [SRC_MAX*RADDR_W_DEF-1:0] bus,
        input int unsigned                    k
    );
        return bus[k*RADDR_W_DEF +: RADDR_W_DEF];
    endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator: flags when the load sitting in EX writes a register that
// the instruction currently in ID reads on any of its source channels.
module load_use_detect
    import pipe_pkg::*;
#(
    parameter int NUM_SRC = NUM_SRC_DEF,
    parameter int RADDR_W = RADDR_W_DEF
) (
    input  logic                       stage_valid_i,
    input  logic                       stage_load_i,
    input  logic [RADDR_W-1:0]         stage_rd_i,
    input  logic                       id_valid_i,
    input  logic [NUM_SRC*RADDR_W-1:0] rs_addr_i,
    output logic                       hazard_o
);

    logic [NUM_SRC-1:0] match;

    generate
        for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_cmp
            assign match[gi] = (rs_addr_i[gi*RADDR_W +: RADDR_W] == stage_rd_i);
        end
    endgenerate

    // x0 is hardwired zero, so a load targeting it can never create a dependency
    assign hazard_o = stage_valid_i & stage_load_i & (stage_rd_i != '0)
                    & id_valid_i & (|match);

endmodule

// File: rtl/id_ex_pipe_stage.sv
// ID->EX stage register with valid bit, stall hold, flush bubble and built-in
// load-use bubble insertion. Define PIPE_PERF_CNT_EN to add saturating event counters.
module id_ex_pipe_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int RADDR_W    = RADDR_W_DEF,
    parameter int NUM_SRC    = NUM_SRC_DEF,
    parameter int WB_W       = WB_W_DEF,
    parameter int M_W        = M_W_DEF,
    parameter int EX_W       = EX_W_DEF,
    parameter int MEM_RD_BIT = MEM_RD_BIT_DEF,
    parameter int CNT_W      = CNT_W_DEF
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       valid_i,
    input  logic                       stall_i,
    input  logic                       flush_i,
    input  logic [NUM_SRC*DATA_W-1:0]  rs_data_i,
    input  logic [NUM_SRC*RADDR_W-1:0] rs_addr_i,
    input  logic [RADDR_W-1:0]         rd_i,
    input  logic [DATA_W-1:0]          imm_i,
    input  logic [WB_W-1:0]            wb_ctrl_i,
    input  logic [M_W-1:0]             m_ctrl_i,
    input  logic [EX_W-1:0]            ex_ctrl_i,
    output logic                       valid_o,
    output logic [NUM_SRC*DATA_W-1:0]  rs_data_o,
    output logic [NUM_SRC*RADDR_W-1:0] rs_addr_o,
    output logic [RADDR_W-1:0]         rd_o,
    output logic [DATA_W-1:0]          imm_o,
    output logic [WB_W-1:0]            wb_ctrl_o,
    output logic [M_W-1:0]             m_ctrl_o,
    output logic [EX_W-1:0]            ex_ctrl_o,
    output logic                       hazard_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]           stall_cnt_o,
    output logic [CNT_W-1:0]           flush_cnt_o,
    output logic [CNT_W-1:0]           bubble_cnt_o
`endif
);

    generate
        if (NUM_SRC < 1 || NUM_SRC > SRC_MAX || MEM_RD_BIT < 0 || MEM_RD_BIT >= M_W
            || CNT_W < 1) begin : g_bad_params
            $error("id_ex_pipe_stage: illegal parameter combination");
        end
    endgenerate

    logic                       valid_q,   valid_d;
    logic [NUM_SRC*DATA_W-1:0]  rs_data_q, rs_data_d;
    logic [NUM_SRC*RADDR_W-1:0] rs_addr_q, rs_addr_d;
    logic [RADDR_W-1:0]         rd_q,      rd_d;
    logic [DATA_W-1:0]          imm_q,     imm_d;
    logic [WB_W-1:0]            wb_ctrl_q, wb_ctrl_d;
    logic [M_W-1:0]             m_ctrl_q,  m_ctrl_d;
    logic [EX_W-1:0]            ex_ctrl_q, ex_ctrl_d;

    stage_sel_e sel;
    logic       hazard;

    load_use_detect #(
        .NUM_SRC (NUM_SRC),
        .RADDR_W (RADDR_W)
    ) u_load_use_detect (
        .stage_valid_i (valid_q),
        .stage_load_i  (m_ctrl_q[MEM_RD_BIT]),
        .stage_rd_i    (rd_q),
        .id_valid_i    (valid_i),
        .rs_addr_i     (rs_addr_i),
        .hazard_o      (hazard)
    );

    // Flush beats stall beats load-use bubble beats a normal load
    always_comb begin
        sel = SEL_LOAD;
        if (flush_i) begin
            sel = SEL_FLUSH;
        end else if (stall_i) begin
            sel = SEL_STALL;
        end else if (hazard) begin
            sel = SEL_BUBBLE;
        end
    end

    always_comb begin
        valid_d   = valid_q;
        rs_data_d = rs_data_q;
        rs_addr_d = rs_addr_q;
        rd_d      = rd_q;
        imm_d     = imm_q;
        wb_ctrl_d = wb_ctrl_q;
        m_ctrl_d  = m_ctrl_q;
        ex_ctrl_d = ex_ctrl_q;
        case (sel)
            SEL_FLUSH, SEL_BUBBLE: begin
                // Operand fields keep their old contents; only valid and control are squashed
                valid_d   = 1'b0;
                wb_ctrl_d = {WB_W{BUBBLE_CTRL}};
                m_ctrl_d  = {M_W{BUBBLE_CTRL}};
                ex_ctrl_d = {EX_W{BUBBLE_CTRL}};
            end
            SEL_STALL: begin
            end
            default: begin
                valid_d   = valid_i;
                rs_data_d = rs_data_i;
                rs_addr_d = rs_addr_i;
                rd_d      = rd_i;
                imm_d     = imm_i;
                wb_ctrl_d = valid_i ? wb_ctrl_i : {WB_W{BUBBLE_CTRL}};
                m_ctrl_d  = valid_i ? m_ctrl_i  : {M_W{BUBBLE_CTRL}};
                ex_ctrl_d = valid_i ? ex_ctrl_i : {EX_W{BUBBLE_CTRL}};
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q   <= 1'b0;
            rs_data_q <= '0;
            rs_addr_q <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            wb_ctrl_q <= '0;
            m_ctrl_q  <= '0;
            ex_ctrl_q <= '0;
        end else begin
            valid_q   <= valid_d;
            rs_data_q <= rs_data_d;
            rs_addr_q <= rs_addr_d;
            rd_q      <= rd_d;
            imm_q     <= imm_d;
            wb_ctrl_q <= wb_ctrl_d;
            m_ctrl_q  <= m_ctrl_d;
            ex_ctrl_q <= ex_ctrl_d;
        end
    end

    assign valid_o   = valid_q;
    assign rs_data_o = rs_data_q;
    assign rs_addr_o = rs_addr_q;
    assign rd_o      = rd_q;
    assign imm_o     = imm_q;
    assign wb_ctrl_o = wb_ctrl_q;
    assign m_ctrl_o  = m_ctrl_q;
    assign ex_ctrl_o = ex_ctrl_q;
    assign hazard_o  = hazard;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Each counter saturates at all-ones; the select guarantees one increment per edge at most
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (sel == SEL_STALL && stall_cnt_q != '1) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
        if (sel == SEL_FLUSH && flush_cnt_q != '1) begin
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
        end
        if (sel == SEL_BUBBLE && bubble_cnt_q != '1) begin
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign flush_cnt_o  = flush_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// Directed-vector bench for id_ex_pipe_stage (default widths, CNT_W=4 so the
// optional PIPE_PERF_CNT_EN counters can be driven into saturation).
module tb_id_ex_pipe_stage;
    import pipe_pkg::*;

    localparam int DATA_W  = 32;
    localparam int RADDR_W = 5;
    localparam int NUM_SRC = 2;
    localparam int WB_W    = 2;
    localparam int M_W     = 2;
    localparam int EX_W    = 4;
    localparam int CNT_W   = 4;

    logic                       clk_i = 1'b0;
    logic                       rst_i;
    logic                       valid_i, stall_i, flush_i;
    logic [NUM_SRC*DATA_W-1:0]  rs_data_i;
    logic [NUM_SRC*RADDR_W-1:0] rs_addr_i;
    logic [RADDR_W-1:0]         rd_i;
    logic [DATA_W-1:0]          imm_i;
    logic [WB_W-1:0]            wb_ctrl_i;
    logic [M_W-1:0]             m_ctrl_i;
    logic [EX_W-1:0]            ex_ctrl_i;
    logic                       valid_o;
    logic [NUM_SRC*DATA_W-1:0]  rs_data_o;
    logic [NUM_SRC*RADDR_W-1:0] rs_addr_o;
    logic [RADDR_W-1:0]         rd_o;
    logic [DATA_W-1:0]          imm_o;
    logic [WB_W-1:0]            wb_ctrl_o;
    logic [M_W-1:0]             m_ctrl_o;
    logic [EX_W-1:0]            ex_ctrl_o;
    logic                       hazard_o;
`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0]           stall_cnt_o, flush_cnt_o, bubble_cnt_o;
`endif

    int n_vec = 0;
    int n_err = 0;

    id_ex_pipe_stage #(
        .DATA_W     (DATA_W),
        .RADDR_W    (RADDR_W),
        .NUM_SRC    (NUM_SRC),
        .WB_W       (WB_W),
        .M_W        (M_W),
        .EX_W       (EX_W),
        .MEM_RD_BIT (0),
        .CNT_W      (CNT_W)
    ) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .stall_i   (stall_i),
        .flush_i   (flush_i),
        .rs_data_i (rs_data_i),
        .rs_addr_i (rs_addr_i),
        .rd_i      (rd_i),
        .imm_i     (imm_i),
        .wb_ctrl_i (wb_ctrl_i),
        .m_ctrl_i  (m_ctrl_i),
        .ex_ctrl_i (ex_ctrl_i),
        .valid_o   (valid_o),
        .rs_data_o (rs_data_o),
        .rs_addr_o (rs_addr_o),
        .rd_o      (rd_o),
        .imm_o     (imm_o),
        .wb_ctrl_o (wb_ctrl_o),
        .m_ctrl_o  (m_ctrl_o),
        .ex_ctrl_o (ex_ctrl_o),
        .hazard_o  (hazard_o)
`ifdef PIPE_PERF_CNT_EN
        ,
        .stall_cnt_o  (stall_cnt_o),
        .flush_cnt_o  (flush_cnt_o),
        .bubble_cnt_o (bubble_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [31:0] d1, input logic [31:0] d0,
                          input logic [31:0] a1, input logic [31:0] a0, input logic [31:0] rd,
                          input logic [31:0] imm, input logic [31:0] wb, input logic [31:0] m,
                          input logic [31:0] ex);
        logic [SRC_MAX*DATA_W_DEF-1:0]  dbus;
        logic [SRC_MAX*RADDR_W_DEF-1:0] abus;
        dbus      = data_pack(d0, d1, '0);
        abus      = addr_pack(a0[RADDR_W-1:0], a1[RADDR_W-1:0], '0);
        valid_i   = v;
        rs_data_i = dbus[NUM_SRC*DATA_W-1:0];
        rs_addr_i = abus[NUM_SRC*RADDR_W-1:0];
        rd_i      = rd[RADDR_W-1:0];
        imm_i     = imm;
        wb_ctrl_i = wb[WB_W-1:0];
        m_ctrl_i  = m[M_W-1:0];
        ex_ctrl_i = ex[EX_W-1:0];
    endtask

    function automatic logic [63:0] ctrl_out();
        return 64'({wb_ctrl_o, m_ctrl_o, ex_ctrl_o});
    endfunction

    initial begin
        logic [SRC_MAX*DATA_W_DEF-1:0] wide;
        rst_i   = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        check("rst_valid", 64'(valid_o), 64'h0);
        check("rst_rd", 64'(rd_o), 64'h0);
        check("rst_ctrl", ctrl_out(), 64'h0);
        check("rst_hazard", 64'(hazard_o), 64'h0);
        rst_i = 1'b1;

        // Pass-through
        set_in(1, 32'h5, 32'h7, 2, 1, 3, 32'hFFFF_FFFC, 3, 2, 4'hA);
        step();
        check("pt_valid", 64'(valid_o), 64'h1);
        check("pt_data", 64'(rs_data_o), 64'h0000_0005_0000_0007);
        wide = {32'h0, rs_data_o};
        check("pt_ch1", 64'(data_chan(wide, 1)), 64'h5);
        check("pt_addr", 64'(rs_addr_o), 64'({5'd2, 5'd1}));
        check("pt_rd", 64'(rd_o), 64'h3);
        check("pt_imm", 64'(imm_o), 64'hFFFF_FFFC);
        check("pt_ctrl", ctrl_out(), 64'hEA);
        check("pt_hazard", 64'(hazard_o), 64'h0);

        // Asynchronous reset mid-cycle with nonzero inputs
        #2 rst_i = 1'b0;
        #1;
        check("arst_valid", 64'(valid_o), 64'h0);
        check("arst_data", 64'(rs_data_o), 64'h0);
        check("arst_imm", 64'(imm_o), 64'h0);
        check("arst_ctrl", ctrl_out(), 64'h0);
        #1 rst_i = 1'b1;
        step();
        check("rel_valid", 64'(valid_o), 64'h1);
        check("rel_rd", 64'(rd_o), 64'h3);

        // valid_i=0 forces control to zero but fields still load
        set_in(0, 1, 2, 3, 4, 7, 32'h10, 3, 3, 4'hF);
        step();
        check("inv_valid", 64'(valid_o), 64'h0);
        check("inv_ctrl", ctrl_out(), 64'h0);
        check("inv_rd", 64'(rd_o), 64'h7);

        // Load-use on channel 1: one bubble, then the held instruction enters
        set_in(1, 32'h11, 32'h22, 1, 2, 5, 4, 1, 1, 0);
        step();
        set_in(1, 32'h33, 32'h44, 5, 6, 8, 8, 1, 0, 3);
        #1;
        check("lu_hazard", 64'(hazard_o), 64'h1);
        step();
        check("lu_bub_valid", 64'(valid_o), 64'h0);
        check("lu_bub_ctrl", ctrl_out(), 64'h0);
        check("lu_bub_rd", 64'(rd_o), 64'h5);
        check("lu_bub_data", 64'(rs_data_o), 64'h0000_0011_0000_0022);
        check("lu_bub_hazard", 64'(hazard_o), 64'h0);
        step();
        check("lu_re_valid", 64'(valid_o), 64'h1);
        check("lu_re_rd", 64'(rd_o), 64'h8);
        check("lu_re_ctrl", ctrl_out(), 64'h43);
        check("lu_re_data", 64'(rs_data_o), 64'h0000_0033_0000_0044);

        // Load-use on channel 0, gated by valid_i
        set_in(1, 0, 0, 3, 4, 9, 0, 1, 1, 0);
        step();
        set_in(1, 0, 0, 0, 9, 10, 0, 0, 0, 0);
        #1;
        check("ch0_hazard", 64'(hazard_o), 64'h1);
        valid_i = 1'b0;
        #1;
        check("ch0_novalid", 64'(hazard_o), 64'h0);

        // Load to x0 never hazards
        set_in(1, 0, 0, 1, 2, 0, 0, 1, 1, 0);
        step();
        set_in(1, 0, 0, 0, 0, 2, 32'h20, 0, 0, 0);
        #1;
        check("x0_hazard", 64'(hazard_o), 64'h0);
        step();
        check("x0_valid", 64'(valid_o), 64'h1);
        check("x0_rd", 64'(rd_o), 64'h2);

        // Stall freezes everything for 3 cycles, release loads the latest input
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1, i, i, 0, 0, 11 + i, 32'h100 + i, 0, 0, 0);
            step();
            check("stall_rd", 64'(rd_o), 64'h2);
            check("stall_imm", 64'(imm_o), 64'h20);
        end
        stall_i = 1'b0;
        step();
        check("unstall_rd", 64'(rd_o), 64'd13);
        check("unstall_imm", 64'(imm_o), 64'h102);

        // Stall while a hazard is pending: no bubble until the stall drops
        set_in(1, 0, 0, 0, 0, 4, 0, 1, 1, 0);
        step();
        set_in(1, 0, 0, 4, 0, 12, 0, 0, 0, 5);
        stall_i = 1'b1;
        #1;
        check("sh_hazard", 64'(hazard_o), 64'h1);
        step();
        check("sh_valid", 64'(valid_o), 64'h1);
        check("sh_ctrl", ctrl_out(), 64'h50);
        check("sh_hazard2", 64'(hazard_o), 64'h1);
        stall_i = 1'b0;
        step();
        check("sh_bub_valid", 64'(valid_o), 64'h0);
        check("sh_bub_ctrl", ctrl_out(), 64'h0);
        step();
        check("sh_re_rd", 64'(rd_o), 64'd12);
        check("sh_re_valid", 64'(valid_o), 64'h1);

        // Flush with a pending hazard: flush wins, hazard_o still shows the compare
        set_in(1, 0, 0, 0, 0, 6, 0, 1, 1, 0);
        step();
        set_in(1, 0, 0, 6, 0, 14, 0, 0, 0, 0);
        flush_i = 1'b1;
        #1;
        check("fh_hazard", 64'(hazard_o), 64'h1);
        step();
        check("fh_valid", 64'(valid_o), 64'h0);
        check("fh_ctrl", ctrl_out(), 64'h0);
        check("fh_rd", 64'(rd_o), 64'h6);
        flush_i = 1'b0;

        // Fresh reset, then flush and stall in the same cycle
        #2 rst_i = 1'b0;
        #2 rst_i = 1'b1;
        set_in(1, 0, 0, 0, 0, 15, 0, 3, 0, 1);
        flush_i = 1'b1;
        stall_i = 1'b1;
        step();
        check("fs_valid", 64'(valid_o), 64'h0);
        check("fs_ctrl", ctrl_out(), 64'h0);
        check("fs_rd", 64'(rd_o), 64'h0);
`ifdef PIPE_PERF_CNT_EN
        check("fs_flush_cnt", 64'(flush_cnt_o), 64'h1);
        check("fs_stall_cnt", 64'(stall_cnt_o), 64'h0);
`endif
        flush_i = 1'b0;
        stall_i = 1'b0;
        step();
        check("fs_load_rd", 64'(rd_o), 64'd15);
        check("fs_load_ctrl", ctrl_out(), 64'hC1);

        // Long stall: 20 cycles saturates the 4-bit stall counter
        stall_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
        end
        check("long_stall_rd", 64'(rd_o), 64'd15);
`ifdef PIPE_PERF_CNT_EN
        check("sat_stall_cnt", 64'(stall_cnt_o), 64'hF);
`endif
        stall_i = 1'b0;

        // One hazard bubble after the stall
        set_in(1, 0, 0, 0, 0, 7, 0, 1, 1, 0);
        step();
        set_in(1, 0, 0, 7, 0, 9, 0, 0, 0, 0);
        step();
        check("bub_valid", 64'(valid_o), 64'h0);
`ifdef PIPE_PERF_CNT_EN
        check("bub_cnt", 64'(bubble_cnt_o), 64'h1);
        check("bub_stall_cnt", 64'(stall_cnt_o), 64'hF);
        check("bub_flush_cnt", 64'(flush_cnt_o), 64'h1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
